pong_score_keeper: RTL and testbench
====================================

# pong_score_keeper

- Game-state controller that owns both players' scores and produces the 3-bit values the per-player bar displays consume.
- Detects goals from the ball logic and applies score updates only on frame boundaries, so a displayed frame never tears.
- Times the pause before each serve in frames, then pulses the ball logic to re-serve.
- Declares game over and the winner when a player's conceded count reaches the limit.

## Interface
- `MAX_SCORE`, default 7: conceded goals that end the game. Legal range 1..7. Display shows 7−score bars.
- `SERVE_FRAMES`, default 60: frames between a score update and the next serve. Legal range 1..255.

- `clk` in 1: system/pixel clock. Single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: one-cycle pulse at start of vertical blanking.
- `start_btn` in 1: debounced, synchronized level. Acts on rising edge.
- `goal_p0` in 1: level, high while the ball is past player 0's edge (player 0 concedes).
- `goal_p1` in 1: same for player 1.
- `score_p0` out 3: goals conceded by player 0, 0..MAX_SCORE.
- `score_p1` out 3: goals conceded by player 1.
- `serve` out 1: one-cycle pulse; ball logic re-centres and launches.
- `serve_dir` out 1: 0 = serve toward player 0, 1 = toward player 1.
- `game_over` out 1: level, high in GAME_OVER.
- `winner` out 1: valid while `game_over`. 0 = player 0 won, 1 = player 1 won.
- `draw` out 1: valid while `game_over`. High when both players maxed on the same frame.

## Operation
- **Reset:** all outputs 0, state IDLE, serve counter 0, pending flags 0, edge registers 0.
- **Rising-edge detection:** `start_btn`, `goal_p0` and `goal_p1` each have a rising-edge detector. The edge registers update in every state, so a level already high on entry never produces an edge.
- **IDLE:**
  - Scores hold 0.
  - `start_btn` edge: counter ← SERVE_FRAMES, `serve_dir` ← 0, go to SERVE_WAIT.
- **SERVE_WAIT:**
  - Each `frame_start` decrements the counter.
  - On the `frame_start` that takes the counter from 1 to 0: go to PLAY and assert `serve` for exactly one cycle.
  - Goal edges are ignored.
- **PLAY:**
  - A goal edge sets pending_p0 or pending_p1. Pending flags are sticky until the next `frame_start`.
  - An edge arriving in the same cycle as `frame_start` is counted in that frame.
  - On `frame_start` with any pending flag set:
    - Each flagged score increments, saturating at MAX_SCORE.
    - Pending flags clear.
    - `serve_dir` ← the conceding player if exactly one is flagged; unchanged if both are flagged.
    - If any updated score equals MAX_SCORE, go to GAME_OVER. Otherwise counter ← SERVE_FRAMES and go to SERVE_WAIT.
  - `frame_start` with no pending flag: no action.
- **GAME_OVER:**
  - `game_over` = 1. Scores frozen. Goal edges ignored.
  - `winner`: 1 if only `score_p0` maxed, 0 if only `score_p1` maxed.
  - `draw` = 1 if both maxed; `winner` = 0 in that case.
  - `start_btn` edge: scores ← 0, `game_over`/`winner`/`draw` ← 0, counter ← SERVE_FRAMES, go to SERVE_WAIT.
- **Reset mid-operation:** immediate return to reset values regardless of state. Any pending goal is lost.

## Timing
- All outputs are registered.
- Goal-edge latency:
  - The goal edge is registered one cycle after the `goal_px` rise.
  - The score changes on the clock edge that samples the next `frame_start`, visible the following cycle.
  - Worst case is one full frame plus 1 cycle.
- `serve` is high the cycle after the final counted `frame_start`.
- PLAY is entered on that same edge; goal edges are accepted from that cycle onward.
- Serve delay is exactly SERVE_FRAMES frame pulses after the score update. The update's own `frame_start` is not counted.
- `game_over` rises the cycle after the deciding `frame_start`, coincident with the final score value.

## Structure
- Shared package `pong_pkg` holds:
  - state enum IDLE/SERVE_WAIT/PLAY/GAME_OVER
  - `SCORE_W` = 3
  - `SERVE_CNT_W` = 8
- Sub-module `rise_detect` (single register plus AND-NOT, async active-low reset), instantiated three times.
- Remainder is one FSM plus the score and counter datapath.

## Test plan
- **Async reset mid-game:** scores 3/2 in PLAY, drop `rst_n` between clock edges → all outputs 0 immediately; IDLE after release.
- **Start and serve:** SERVE_FRAMES=2, `start_btn` edge, two `frame_start` pulses → `serve` high exactly one cycle after the second pulse, `serve_dir`=0, no earlier pulse.
- **Held goal level:** `goal_p1` held high 3 frames in PLAY → `score_p1` 0→1 once at the next `frame_start`, `serve_dir`=1, no further increment while the level stays high.
- **Simultaneous goals:** both goal edges in the same PLAY frame → scores 1/1, `serve_dir` unchanged; a goal during SERVE_WAIT → scores unchanged.
- **Win:** `score_p1`=6, `goal_p1` edge, `frame_start` → `score_p1`=7, `game_over`=1, `winner`=0, `draw`=0; further goals ignored; `start_btn` edge → scores 0/0, `game_over`=0.
- **Draw:** both scores 6, simultaneous goals → both 7, `game_over`=1, `draw`=1, `winner`=0.

Source files
------------

// File: rtl/pong_score_keeper_pkg.sv
// Shared types and widths for the pong game-state controller.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2,
        GAME_OVER  = 2'd3
    } state_t;

    localparam int SCORE_W     = 3;
    localparam int SERVE_CNT_W = 8;

endpackage

// File: rtl/pong_score_keeper_rise_detect.sv
// Single-register rising-edge detector; the edge output is combinational off the registered level.
module rise_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev <= 1'b0;
        else          r_prev <= i_level;
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/pong_score_keeper.sv
// Pong game-state controller: scores, frame-aligned goal updates, serve timing, game over.
module pong_score_keeper
    import pong_pkg::*;
#(
    parameter int MAX_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_start,
    input  logic               i_start_btn,
    input  logic               i_goal_p0,
    input  logic               i_goal_p1,
    output logic [SCORE_W-1:0] o_score_p0,
    output logic [SCORE_W-1:0] o_score_p1,
    output logic               o_serve,
    output logic               o_serve_dir,
    output logic               o_game_over,
    output logic               o_winner,
    output logic               o_draw
);

    localparam logic [SCORE_W-1:0]     MAX_S    = SCORE_W'(MAX_SCORE);
    localparam logic [SERVE_CNT_W-1:0] CNT_INIT = SERVE_CNT_W'(SERVE_FRAMES);

    state_t                 r_state;
    logic [SERVE_CNT_W-1:0] r_cnt;
    logic [SCORE_W-1:0]     r_score_p0, r_score_p1;
    logic                   r_pend_p0, r_pend_p1;
    logic                   r_serve, r_serve_dir, r_game_over, r_winner, r_draw;

    logic w_start_rise, w_goal0_rise, w_goal1_rise;

    rise_detect u_rd_start (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_level(i_start_btn), .o_rise(w_start_rise));
    rise_detect u_rd_goal0 (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_level(i_goal_p0),   .o_rise(w_goal0_rise));
    rise_detect u_rd_goal1 (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_level(i_goal_p1),   .o_rise(w_goal1_rise));

    // Folding the live edge into pending lets a goal on the frame_start cycle count in that frame.
    logic               w_pend0, w_pend1;
    logic [SCORE_W-1:0] w_upd0, w_upd1;
    logic               w_max0, w_max1;

    assign w_pend0 = r_pend_p0 | w_goal0_rise;
    assign w_pend1 = r_pend_p1 | w_goal1_rise;
    assign w_upd0  = (w_pend0 && r_score_p0 != MAX_S) ? r_score_p0 + 1'b1 : r_score_p0;
    assign w_upd1  = (w_pend1 && r_score_p1 != MAX_S) ? r_score_p1 + 1'b1 : r_score_p1;
    assign w_max0  = (w_upd0 == MAX_S);
    assign w_max1  = (w_upd1 == MAX_S);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_score_p0  <= '0;
            r_score_p1  <= '0;
            r_pend_p0   <= 1'b0;
            r_pend_p1   <= 1'b0;
            r_serve     <= 1'b0;
            r_serve_dir <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
            r_draw      <= 1'b0;
        end else begin
            r_serve <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_rise) begin
                        r_cnt       <= CNT_INIT;
                        r_serve_dir <= 1'b0;
                        r_state     <= SERVE_WAIT;
                    end
                end
                SERVE_WAIT: begin
                    if (i_frame_start) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == SERVE_CNT_W'(1)) begin
                            r_serve <= 1'b1;
                            r_state <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (!i_frame_start) begin
                        r_pend_p0 <= w_pend0;
                        r_pend_p1 <= w_pend1;
                    end else if (w_pend0 || w_pend1) begin
                        r_score_p0 <= w_upd0;
                        r_score_p1 <= w_upd1;
                        r_pend_p0  <= 1'b0;
                        r_pend_p1  <= 1'b0;
                        if (w_pend0 ^ w_pend1) r_serve_dir <= w_pend1;
                        if (w_max0 || w_max1) begin
                            r_game_over <= 1'b1;
                            r_winner    <= w_max0 & ~w_max1;
                            r_draw      <= w_max0 & w_max1;
                            r_state     <= GAME_OVER;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_state <= SERVE_WAIT;
                        end
                    end
                end
                GAME_OVER: begin
                    if (w_start_rise) begin
                        r_score_p0  <= '0;
                        r_score_p1  <= '0;
                        r_game_over <= 1'b0;
                        r_winner    <= 1'b0;
                        r_draw      <= 1'b0;
                        r_cnt       <= CNT_INIT;
                        r_state     <= SERVE_WAIT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_score_p0  = r_score_p0;
    assign o_score_p1  = r_score_p1;
    assign o_serve     = r_serve;
    assign o_serve_dir = r_serve_dir;
    assign o_game_over = r_game_over;
    assign o_winner    = r_winner;
    assign o_draw      = r_draw;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed bench for pong_score_keeper with SERVE_FRAMES=2, MAX_SCORE=7.
module tb_pong_score_keeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       start_btn = 1'b0;
    logic       goal_p0 = 1'b0;
    logic       goal_p1 = 1'b0;
    logic [2:0] score_p0, score_p1;
    logic       serve, serve_dir, game_over, winner, draw;

    int total = 0;
    int bad   = 0;

    pong_score_keeper #(.MAX_SCORE(7), .SERVE_FRAMES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
        .i_start_btn(start_btn), .i_goal_p0(goal_p0), .i_goal_p1(goal_p1),
        .o_score_p0(score_p0), .o_score_p1(score_p1), .o_serve(serve),
        .o_serve_dir(serve_dir), .o_game_over(game_over), .o_winner(winner), .o_draw(draw)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs reflecting the sampled frame_start are visible on return.
    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic goal(input logic g0, input logic g1);
        goal_p0 = g0;
        goal_p1 = g1;
        tick();
        goal_p0 = 1'b0;
        goal_p1 = 1'b0;
        tick();
    endtask

    task automatic serve_wait(input string tag);
        tick();
        frame();
        tick();
        frame();
        chk(tag, serve, 1);
        tick();
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_score_p0", score_p0, 0);
        chk("rst_score_p1", score_p1, 0);
        chk("rst_serve", serve, 0);
        chk("rst_dir", serve_dir, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        chk("rst_draw", draw, 0);
        rst_n = 1'b1;
        tick();

        // start and serve
        press_start();
        tick();
        frame();
        chk("early_serve", serve, 0);
        tick();
        frame();
        chk("serve_after_2", serve, 1);
        chk("serve_dir_start", serve_dir, 0);
        tick();
        chk("serve_one_cycle", serve, 0);

        // held goal level
        goal_p1 = 1'b1;
        tick();
        tick();
        frame();
        chk("held_p1_inc", score_p1, 1);
        chk("held_p0", score_p0, 0);
        chk("held_dir", serve_dir, 1);
        serve_wait("held_serve");
        frame();
        tick();
        frame();
        chk("held_no_reinc", score_p1, 1);
        goal_p1 = 1'b0;
        tick();

        // simultaneous goals
        goal(1'b1, 1'b1);
        frame();
        chk("simul_p0", score_p0, 1);
        chk("simul_p1", score_p1, 2);
        chk("simul_dir", serve_dir, 1);
        goal(1'b1, 1'b0);
        tick();
        frame();
        tick();
        frame();
        chk("sw_goal_serve", serve, 1);
        chk("sw_goal_p0", score_p0, 1);
        chk("sw_goal_p1", score_p1, 2);
        tick();

        // goal edge on the frame_start cycle counts in that frame
        goal_p0 = 1'b1;
        frame();
        goal_p0 = 1'b0;
        chk("same_cycle_p0", score_p0, 2);
        chk("same_cycle_dir", serve_dir, 0);
        serve_wait("same_cycle_serve");
        goal(1'b1, 1'b0);
        frame();
        chk("pre_reset_p0", score_p0, 3);
        chk("pre_reset_p1", score_p1, 2);
        serve_wait("pre_reset_serve");

        // async reset between edges
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_p0", score_p0, 0);
        chk("areset_p1", score_p1, 0);
        chk("areset_dir", serve_dir, 0);
        chk("areset_serve", serve, 0);
        chk("areset_go", game_over, 0);
        tick();
        rst_n = 1'b1;
        tick();
        frame();
        tick();
        frame();
        chk("idle_no_serve", serve, 0);
        goal(1'b0, 1'b1);
        frame();
        chk("idle_no_score", score_p1, 0);
        tick();

        // win for player 0
        press_start();
        serve_wait("win_start_serve");
        for (int i = 0; i < 6; i++) begin
            goal(1'b0, 1'b1);
            frame();
            serve_wait("win_round_serve");
        end
        chk("win_p1_6", score_p1, 6);
        chk("win_go_pre", game_over, 0);
        goal(1'b0, 1'b1);
        frame();
        chk("win_p1_7", score_p1, 7);
        chk("win_go", game_over, 1);
        chk("win_winner", winner, 0);
        chk("win_draw", draw, 0);
        goal(1'b1, 1'b1);
        frame();
        chk("frozen_p0", score_p0, 0);
        chk("frozen_p1", score_p1, 7);
        chk("frozen_go", game_over, 1);
        tick();
        press_start();
        chk("restart_p0", score_p0, 0);
        chk("restart_p1", score_p1, 0);
        chk("restart_go", game_over, 0);
        serve_wait("restart_serve");

        // draw
        for (int i = 0; i < 6; i++) begin
            goal(1'b1, 1'b1);
            frame();
            serve_wait("draw_round_serve");
        end
        chk("draw_p0_6", score_p0, 6);
        chk("draw_p1_6", score_p1, 6);
        goal(1'b1, 1'b1);
        frame();
        chk("draw_p0_7", score_p0, 7);
        chk("draw_p1_7", score_p1, 7);
        chk("draw_go", game_over, 1);
        chk("draw_flag", draw, 1);
        chk("draw_winner", winner, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
